stage_memory: RTL and testbench

- Pipeline stage 4. Consumes the EX/MEM register, which is fed by the execute stage's ALU result, store data, funct3, rd and control bits.
- Runs a request/response handshake with data memory and generates byte enables and store-data lanes.
- Aligns and sign/zero-extends load data.
- Detects misaligned and timed-out accesses.
- Produces the MEM/WB payload. Its out_data is also the MEMWB forwarding source for execute.
- Asserts out_stall to freeze IF..EX/MEM while an access is outstanding.

---
 rtl/stage_memory.sv | 173 +++++++++++++++++
 tb/tb_stage_memory.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory.sv
// Pipeline stage 4: data-memory handshake, store lane steering, load alignment,
// misalignment/timeout detection and MEM/WB payload generation.
module stage_memory #(
  parameter int unsigned TIMEOUT_CYCLES     = 16,
  parameter logic [2:0]  EXC_LOAD_MISALIGN  = 3'b011,
  parameter logic [2:0]  EXC_STORE_MISALIGN = 3'b100,
  parameter logic [2:0]  EXC_ACCESS_FAULT   = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_mem_in_data,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [4:0]  in_rd,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  input  logic [2:0]  in_exception_vector,
  output logic        out_mem_req,
  output logic        out_mem_we,
  output logic [31:0] out_mem_addr,
  output logic [31:0] out_mem_wdata,
  output logic [3:0]  out_mem_be,
  input  logic        in_mem_ready,
  input  logic        in_mem_rvalid,
  input  logic [31:0] in_mem_rdata,
  output logic        out_stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_mem_to_reg,
  output logic        out_write_enable,
  output logic [2:0]  out_exception_vector
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;

  logic               is_mem;
  logic               misalign;
  logic               access;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        load_data;

  assign is_mem         = in_mem_read | in_mem_write;
  assign access         = in_valid & is_mem & (in_exception_vector == 3'b000) & ~misalign;
  assign out_mem_addr   = {in_alu_out[31:2], 2'b00};
  assign out_rd         = in_rd;
  assign out_mem_to_reg = in_mem_to_reg;

  // Encodings 011, 110 and 111 have no access size here and are rejected as misaligned.
  always_comb begin
    misalign = 1'b0;
    if (in_funct3 == 3'b011 || in_funct3[2:1] == 2'b11) misalign = 1'b1;
    else if (in_funct3[1:0] == 2'b01)                   misalign = in_alu_out[0];
    else if (in_funct3[1:0] == 2'b10)                   misalign = |in_alu_out[1:0];
  end

  always_comb begin
    out_mem_wdata = in_mem_in_data;
    out_mem_be    = 4'b1111;
    if (in_mem_write) begin
      case (in_funct3[1:0])
        2'b00: begin
          out_mem_wdata = {4{in_mem_in_data[7:0]}};
          out_mem_be    = 4'b0001 << in_alu_out[1:0];
        end
        2'b01: begin
          out_mem_wdata = {2{in_mem_in_data[15:0]}};
          out_mem_be    = in_alu_out[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (in_alu_out[1:0])
      2'b00:   ld_byte = rdata_q[7:0];
      2'b01:   ld_byte = rdata_q[15:8];
      2'b10:   ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = in_alu_out[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (in_funct3[1:0])
      2'b00:   load_data = in_funct3[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_data = in_funct3[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    state_d              = state_q;
    rdata_d              = rdata_q;
    cnt_d                = cnt_q;
    fault_d              = fault_q;
    out_mem_req          = 1'b0;
    out_mem_we           = 1'b0;
    out_stall            = 1'b0;
    out_valid            = 1'b0;
    out_data             = in_alu_out;
    out_exception_vector = in_exception_vector;
    case (state_q)
      IDLE: begin
        fault_d = 1'b0;
        if (access) begin
          out_mem_req = 1'b1;
          out_mem_we  = in_mem_write;
          out_stall   = 1'b1;
          if (in_mem_ready) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else begin
          out_valid = in_valid;
          if (in_valid && is_mem && in_exception_vector == 3'b000 && misalign)
            out_exception_vector = in_mem_read ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
        end
      end
      WAIT: begin
        out_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (in_mem_rvalid) begin
          rdata_d = in_mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
        if (in_mem_read && !fault_q) out_data = load_data;
        if (fault_q) out_exception_vector = EXC_ACCESS_FAULT;
      end
      default: state_d = IDLE;
    endcase
    // Nothing leaves the stage while reset is held, even if EX/MEM looks valid.
    if (reset) begin
      out_mem_req = 1'b0;
      out_mem_we  = 1'b0;
      out_stall   = 1'b0;
      out_valid   = 1'b0;
    end
    out_write_enable = in_write_enable & out_valid & (out_exception_vector == 3'b000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: IDLE-cycle vector table plus hand-written
// multi-cycle sequences (loads, store ack, timeout, stale rvalid, reset in WAIT).
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_out;
  logic [31:0] in_mem_in_data;
  logic [2:0]  in_funct3;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [4:0]  in_rd;
  logic        in_mem_to_reg;
  logic        in_write_enable;
  logic [2:0]  in_exception_vector;
  logic        out_mem_req;
  logic        out_mem_we;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_wdata;
  logic [3:0]  out_mem_be;
  logic        in_mem_ready;
  logic        in_mem_rvalid;
  logic [31:0] in_mem_rdata;
  logic        out_stall;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_mem_to_reg;
  logic        out_write_enable;
  logic [2:0]  out_exception_vector;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  stage_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_out(in_alu_out),
    .in_mem_in_data(in_mem_in_data), .in_funct3(in_funct3), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg),
    .in_write_enable(in_write_enable), .in_exception_vector(in_exception_vector),
    .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
    .out_mem_wdata(out_mem_wdata), .out_mem_be(out_mem_be), .in_mem_ready(in_mem_ready),
    .in_mem_rvalid(in_mem_rvalid), .in_mem_rdata(in_mem_rdata), .out_stall(out_stall),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_mem_to_reg(out_mem_to_reg), .out_write_enable(out_write_enable),
    .out_exception_vector(out_exception_vector)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdat;
    logic [2:0]  f3;
    logic        rd_op;
    logic        wr_op;
    logic        wen;
    logic [2:0]  exc;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_wen;
    logic [2:0]  e_exc;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] f, input logic r, input logic w, input logic we,
                              input logic [2:0] x, input logic q, input logic qw, input logic [31:0] qa,
                              input logic [31:0] qd, input logic [3:0] qb, input logic s, input logic ov,
                              input logic [31:0] od, input logic owe, input logic [2:0] ox);
    vec_t t;
    t.name = nm; t.valid = v; t.alu = a; t.wdat = d; t.f3 = f; t.rd_op = r; t.wr_op = w;
    t.wen = we; t.exc = x; t.e_req = q; t.e_we = qw; t.e_addr = qa; t.e_wdata = qd;
    t.e_be = qb; t.e_stall = s; t.e_valid = ov; t.e_data = od; t.e_wen = owe; t.e_exc = ox;
    return t;
  endfunction

  task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input logic r, input logic w, input logic we, input logic [2:0] x);
    in_valid = v; in_alu_out = a; in_mem_in_data = d; in_funct3 = f;
    in_mem_read = r; in_mem_write = w; in_write_enable = we; in_exception_vector = x;
    in_rd = 5'd7; in_mem_to_reg = r;
  endtask

  task automatic chk(input string nm, input logic e_req, input logic e_stall, input logic e_valid,
                     input logic e_wen, input logic [2:0] e_exc);
    vec_count++;
    if (out_mem_req !== e_req || out_stall !== e_stall || out_valid !== e_valid ||
        out_write_enable !== e_wen || out_exception_vector !== e_exc) begin
      miss_count++;
      $display("FAIL %s: got req=%b stall=%b valid=%b wen=%b exc=%0d, expected req=%b stall=%b valid=%b wen=%b exc=%0d",
               nm, out_mem_req, out_stall, out_valid, out_write_enable, out_exception_vector,
               e_req, e_stall, e_valid, e_wen, e_exc);
    end
  endtask

  task automatic chk_data(input string nm, input logic [31:0] e_data);
    vec_count++;
    if (out_data !== e_data || out_rd !== in_rd || out_mem_to_reg !== in_mem_to_reg) begin
      miss_count++;
      $display("FAIL %s: got data=%h rd=%0d m2r=%b, expected data=%h rd=%0d m2r=%b",
               nm, out_data, out_rd, out_mem_to_reg, e_data, in_rd, in_mem_to_reg);
    end
  endtask

  task automatic chk_bus(input string nm, input logic e_we, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input logic [3:0] e_be);
    vec_count++;
    if (out_mem_we !== e_we || out_mem_addr !== e_addr || out_mem_be !== e_be ||
        (e_we && out_mem_wdata !== e_wdata)) begin
      miss_count++;
      $display("FAIL %s: got we=%b addr=%h wdata=%h be=%b, expected we=%b addr=%h wdata=%h be=%b",
               nm, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_be, e_we, e_addr, e_wdata, e_be);
    end
  endtask

  task automatic idle_inputs();
    set_op(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
    in_mem_ready = 1'b0; in_mem_rvalid = 1'b0; in_mem_rdata = 32'h0;
  endtask

  // One complete load with ready on the first cycle and rvalid on the second.
  task automatic run_load(input string nm, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] rdata, input logic [31:0] e_data);
    @(negedge clk);
    set_op(1'b1, a, 32'h0, f, 1'b1, 1'b0, 1'b1, 3'b000);
    in_mem_ready = 1'b1;
    #2 chk({nm, "_issue"}, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    in_mem_ready = 1'b0; in_mem_rvalid = 1'b1; in_mem_rdata = rdata;
    #2 chk({nm, "_wait"}, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    in_mem_rvalid = 1'b0; in_mem_rdata = 32'h0;
    #2 chk({nm, "_done"}, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    chk_data({nm, "_data"}, e_data);
    @(negedge clk);
    in_valid = 1'b0;
    #2 chk({nm, "_after"}, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  vec_t vecs[$];

  initial begin
    //          name      v  alu           wdat          f3     r  w  we x   req we addr          wdata         be       st ov data          wen exc
    vecs.push_back(mk("alu",      1, 32'h0000_1234, 32'h0,        3'b000, 0, 0, 1, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_1234, 1, 3'd0));
    vecs.push_back(mk("bubble",   0, 32'h0000_0005, 32'h0,        3'b000, 0, 0, 1, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0,         0, 3'd0));
    vecs.push_back(mk("lw_mis",   1, 32'h0000_3001, 32'h0,        3'b010, 1, 0, 1, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_3001, 0, 3'd3));
    vecs.push_back(mk("sh_mis",   1, 32'h0000_2003, 32'h0,        3'b001, 0, 1, 0, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_2003, 0, 3'd4));
    vecs.push_back(mk("lh_mis",   1, 32'h0000_0011, 32'h0,        3'b001, 1, 0, 1, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_0011, 0, 3'd3));
    vecs.push_back(mk("ld_f3_3",  1, 32'h0000_0000, 32'h0,        3'b011, 1, 0, 1, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0,         0, 3'd3));
    vecs.push_back(mk("st_f3_6",  1, 32'h0000_0000, 32'h0,        3'b110, 0, 1, 0, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0,         0, 3'd4));
    vecs.push_back(mk("lhu_mis",  1, 32'h0000_7001, 32'h0,        3'b101, 1, 0, 1, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_7001, 0, 3'd3));
    vecs.push_back(mk("up_exc",   1, 32'h0000_0100, 32'h0,        3'b010, 1, 0, 1, 2,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_0100, 0, 3'd2));
    vecs.push_back(mk("mis_inv",  0, 32'h0000_0003, 32'h0,        3'b010, 1, 0, 1, 0,  0, 0, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0,         0, 3'd0));
    vecs.push_back(mk("sb_b1",    1, 32'h0000_4001, 32'hDEAD_BEEF, 3'b000, 0, 1, 0, 0,  1, 1, 32'h0000_4000, 32'hEFEF_EFEF, 4'b0010, 1, 0, 32'h0,         0, 3'd0));
    vecs.push_back(mk("sb_b3",    1, 32'h0000_4003, 32'h0000_00A5, 3'b000, 0, 1, 0, 0,  1, 1, 32'h0000_4000, 32'hA5A5_A5A5, 4'b1000, 1, 0, 32'h0,         0, 3'd0));
    vecs.push_back(mk("sh_hi",    1, 32'h0000_2002, 32'hABCD_1234, 3'b001, 0, 1, 0, 0,  1, 1, 32'h0000_2000, 32'h1234_1234, 4'b1100, 1, 0, 32'h0,         0, 3'd0));
    vecs.push_back(mk("sh_lo",    1, 32'h0000_2000, 32'hABCD_1234, 3'b001, 0, 1, 0, 0,  1, 1, 32'h0000_2000, 32'h1234_1234, 4'b0011, 1, 0, 32'h0,         0, 3'd0));
    vecs.push_back(mk("sw",       1, 32'h0000_5004, 32'h0123_4567, 3'b010, 0, 1, 0, 0,  1, 1, 32'h0000_5004, 32'h0123_4567, 4'b1111, 1, 0, 32'h0,         0, 3'd0));
    vecs.push_back(mk("lw_req",   1, 32'h0000_6008, 32'h0,        3'b010, 1, 0, 1, 0,  1, 0, 32'h0000_6008, 32'h0,        4'b1111, 1, 0, 32'h0,         0, 3'd0));
    vecs.push_back(mk("lbu_req",  1, 32'h0000_7003, 32'h0,        3'b100, 1, 0, 1, 0,  1, 0, 32'h0000_7000, 32'h0,        4'b1111, 1, 0, 32'h0,         0, 3'd0));

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #2 chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    #2 chk("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    // In IDLE with ready low, every vector is purely combinational.
    foreach (vecs[i]) begin
      @(negedge clk);
      set_op(vecs[i].valid, vecs[i].alu, vecs[i].wdat, vecs[i].f3, vecs[i].rd_op, vecs[i].wr_op,
             vecs[i].wen, vecs[i].exc);
      #2 chk(vecs[i].name, vecs[i].e_req, vecs[i].e_stall, vecs[i].e_valid, vecs[i].e_wen, vecs[i].e_exc);
      if (vecs[i].e_req) chk_bus({vecs[i].name, "_bus"}, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be);
      if (vecs[i].e_valid) chk_data({vecs[i].name, "_data"}, vecs[i].e_data);
    end
    @(negedge clk);
    idle_inputs();

    run_load("lb",  32'h0000_1003, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80);
    run_load("lbu", 32'h0000_1003, 3'b100, 32'h80FF_0000, 32'h0000_0080);
    run_load("lb2", 32'h0000_1002, 3'b000, 32'h80FF_0000, 32'hFFFF_FFFF);
    run_load("lh",  32'h0000_1002, 3'b001, 32'h80FF_0000, 32'hFFFF_80FF);
    run_load("lhu", 32'h0000_1002, 3'b101, 32'h80FF_0000, 32'h0000_80FF);
    run_load("lh0", 32'h0000_1000, 3'b001, 32'h80FF_0000, 32'h0000_0000);
    run_load("lw",  32'h0000_1000, 3'b010, 32'h80FF_0000, 32'h80FF_0000);

    // Store with ack: bus fields, then payload with write enable gated by in_write_enable=0.
    @(negedge clk);
    set_op(1'b1, 32'h0000_2002, 32'hABCD_1234, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000);
    in_mem_ready = 1'b1;
    #2 chk("sh_issue", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    chk_bus("sh_issue_bus", 1'b1, 32'h0000_2000, 32'h1234_1234, 4'b1100);
    @(negedge clk);
    in_mem_ready = 1'b0; in_mem_rvalid = 1'b1;
    #2 chk("sh_wait", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    in_mem_rvalid = 1'b0;
    #2 chk("sh_done", 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    chk_data("sh_done_data", 32'h0000_2002);
    @(negedge clk);
    idle_inputs();

    // Ready low for 3 cycles, then 4 WAIT cycles without response -> access fault.
    @(negedge clk);
    set_op(1'b1, 32'h0000_8000, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("to_hold%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
      @(negedge clk);
    end
    in_mem_ready = 1'b1;
    #2 chk("to_accept", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_mem_ready = 1'b0;
      #2 chk($sformatf("to_wait%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    end
    @(negedge clk);
    #2 chk("to_fault", 1'b0, 1'b0, 1'b1, 1'b0, 3'd5);
    @(negedge clk);
    idle_inputs();
    #2 chk("to_after", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    // Response arriving on the last allowed WAIT cycle still completes normally.
    @(negedge clk);
    set_op(1'b1, 32'h0000_8004, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000);
    in_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_mem_ready = 1'b0;
      in_mem_rvalid = (i == 3);
      in_mem_rdata = 32'h1357_9BDF;
      #2 chk($sformatf("edge_wait%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    end
    @(negedge clk);
    in_mem_rvalid = 1'b0;
    #2 chk("edge_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    chk_data("edge_data", 32'h1357_9BDF);
    @(negedge clk);
    idle_inputs();

    // Stale rvalid in IDLE is ignored.
    in_mem_rvalid = 1'b1; in_mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #2 chk($sformatf("stale%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    end
    @(negedge clk);
    in_mem_rvalid = 1'b0;
    set_op(1'b1, 32'h0000_00AA, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000);
    #2 chk("stale_alu", 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    chk_data("stale_alu_data", 32'h0000_00AA);

    // Reset while in WAIT, then a late rvalid.
    @(negedge clk);
    set_op(1'b1, 32'h0000_9000, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000);
    in_mem_ready = 1'b1;
    #2 chk("rst_issue", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    in_mem_ready = 1'b0;
    #2 chk("rst_wait", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    #2 chk("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    reset = 1'b0; in_mem_rvalid = 1'b1; in_mem_rdata = 32'h5555_5555;
    #2 chk("rst_late_rvalid", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    in_mem_rvalid = 1'b0;
    #2 chk("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    set_op(1'b1, 32'h0000_0BEE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000);
    #2 chk("rst_alu", 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    chk_data("rst_alu_data", 32'h0000_0BEE);

    @(negedge clk);
    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
